// File: rtl/dct2_1d_row_sched.sv
// -----------------------------------------------------------------------------
// dct2_1d_row_sched
//
// Row scheduler wrapped around a combinational 1-D DCT-II core. A block is
// configured with a size code, then exactly S = 4 << cfg_n row vectors are
// streamed through the core. The input row is registered (stage 1 drives
// core_x) and the core result is registered (stage 2 drives out_data). The
// result is a two-stage pipeline that runs at one row per cycle, with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_start, cfg_n    start a block with size code (00=4, 01=8, 10=16, 11=32)
//   busy, done          block in progress / one-cycle completion pulse
//   in_valid/in_ready   input row handshake, in_data lane 0 in the MSBs
//   core_x, core_n      registered row and latched size code to the DCT core
//   core_y              DCT core result (combinational from core_x/core_n)
//   out_valid/out_ready output handshake
//   out_data            registered coefficients
//   out_row, out_last   row index of out_data, and a flag marking row S-1
//
// Build option: define DCT_LANE_MASK_EN to force lanes >= S to zero in both
// pipeline registers. When the macro is undefined, all 32 lanes pass through
// unmodified.
// -----------------------------------------------------------------------------
module dct2_1d_row_sched #(
  parameter int W     = 16,
  parameter int LANES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [1:0]         cfg_n,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W*LANES-1:0] in_data,
  output logic [W*LANES-1:0] core_x,
  output logic [1:0]         core_n,
  input  logic [W*LANES-1:0] core_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W*LANES-1:0] out_data,
  output logic [4:0]         out_row,
  output logic               out_last
);

  localparam int VW = W * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      in_cnt_q, in_cnt_d;
  logic [1:0]      core_n_q, core_n_d;
  logic            done_q, done_d;

  logic [VW-1:0]   core_x_q, core_x_d;
  logic            s1_v_q, s1_v_d;
  logic [4:0]      s1_tag_q, s1_tag_d;

  logic [VW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [4:0]      out_row_q, out_row_d;
  logic            out_last_q, out_last_d;

  logic [5:0]      s_val;
  logic            s2_free, s1_free, in_fire, s2_load, out_fire;

`ifdef DCT_LANE_MASK_EN
  // Zero every lane whose index is at or above the active row length S.
  function automatic logic [VW-1:0] lane_mask(input logic [VW-1:0] v,
                                              input logic [1:0]    n);
    logic [VW-1:0] r;
    r = v;
    for (int i = 0; i < LANES; i++) begin
      if (i >= (4 << n)) r[VW-1-W*i -: W] = '0;
    end
    return r;
  endfunction
`endif

  // 4 << 3 = 32 still fits in six bits, which is why in_cnt is six bits wide.
  assign s_val = 6'd4 << core_n_q;

  // Stage 2 can take new data if it is empty or is being drained this cycle;
  // stage 1 can take new data if it is empty or is moving into stage 2.
  assign s2_free  = !out_valid_q || out_ready;
  assign s1_free  = !s1_v_q || s2_free;
  assign in_ready = (state_q == RUN) && (in_cnt_q < s_val) && s1_free;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_v_q && s2_free;
  assign out_fire = out_valid_q && out_ready;

  // Control FSM: block configuration, input row count, completion.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    core_n_d = core_n_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          core_n_d = cfg_n;
          in_cnt_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (in_fire) begin
          in_cnt_d = in_cnt_q + 6'd1;
          if (in_cnt_q == s_val - 6'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && out_last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-register datapath.
  always_comb begin
    core_x_d    = core_x_q;
    s1_v_d      = s1_v_q;
    s1_tag_d    = s1_tag_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;

    // Stage 2 holds its contents while stalled; it empties when it is drained
    // and nothing replaces it.
    if (s2_load) begin
`ifdef DCT_LANE_MASK_EN
      out_data_d = lane_mask(core_y, core_n_q);
`else
      out_data_d = core_y;
`endif
      out_valid_d = 1'b1;
      out_row_d   = s1_tag_q;
      out_last_d  = ({1'b0, s1_tag_q} == s_val - 6'd1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
`ifdef DCT_LANE_MASK_EN
      core_x_d = lane_mask(in_data, core_n_q);
`else
      core_x_d = in_data;
`endif
      s1_v_d   = 1'b1;
      s1_tag_d = in_cnt_q[4:0];
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end
  end

  // Datapath registers are reset as well, so that core_x and out_data
  // come up at a known zero value rather than carrying stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      core_n_q    <= 2'b00;
      done_q      <= 1'b0;
      core_x_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_tag_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop in this block updates
      // from the values that held before the clock edge.
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      core_n_q    <= core_n_d;
      done_q      <= done_d;
      core_x_q    <= core_x_d;
      s1_v_q      <= s1_v_d;
      s1_tag_q    <= s1_tag_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
    end
  end

  // busy drops in the same cycle that done pulses, because both change on
  // the edge that returns the FSM to IDLE.
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign core_x    = core_x_q;
  assign core_n    = core_n_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct2_1d_row_sched.sv
// -----------------------------------------------------------------------------
// tb_dct2_1d_row_sched
//
// Scoreboard bench for dct2_1d_row_sched. A stand-in DCT core
// (core_y = ~core_x ^ core_n) makes every result depend on both the
// registered row and the size code. An expected result is queued when an input
// row is accepted, and is compared when the matching output row is accepted.
// Honours DCT_LANE_MASK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_dct2_1d_row_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [1:0]   cfg_n;
  logic         busy, done;
  logic         in_valid, in_ready;
  logic [511:0] in_data;
  logic [511:0] core_x, core_y;
  logic [1:0]   core_n;
  logic         out_valid, out_ready;
  logic [511:0] out_data;
  logic [4:0]   out_row;
  logic         out_last;

  dct2_1d_row_sched #(.W(16), .LANES(32)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_n(cfg_n),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .core_x(core_x), .core_n(core_n), .core_y(core_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Stand-in core.
  assign core_y = ~core_x ^ {510'd0, core_n};

  typedef struct {
    logic [511:0] data;
    logic [4:0]   row;
    logic         last;
  } exp_t;

  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  // Per-block observations collected by sb_cycle.
  int           blk_n, exp_row;
  int           cyc, n_acc, n_out, done_cnt, done_cyc, extra_ready;
  int           first_acc_cyc, first_vld_cyc, first_out_cyc, last_out_cyc;
  logic         done_busy, saw_drop;
  logic         held_v;
  logic [511:0] held_data;
  logic [4:0]   held_row;
  logic         held_last;

  function automatic logic [511:0] mask_ref(input logic [511:0] v, input int n);
    logic [511:0] r;
    r = v;
    for (int l = (4 << n); l < 32; l++) r[511-16*l -: 16] = 16'h0000;
    return r;
  endfunction

  function automatic logic [511:0] exp_out(input logic [511:0] x, input int n);
    logic [511:0] y;
`ifdef DCT_LANE_MASK_EN
    y = mask_ref(~mask_ref(x, n) ^ {510'd0, 2'(n)}, n);
`else
    y = ~x ^ {510'd0, 2'(n)};
`endif
    return y;
  endfunction

  function automatic logic [511:0] rand_row();
    logic [511:0] r;
    for (int l = 0; l < 32; l++) r[16*l +: 16] = 16'($urandom);
    return r;
  endfunction

  // One clock cycle: sample at the falling edge, then return 1 time unit
  // after the next rising edge so the caller can drive new inputs.
  task automatic sb_cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (in_ready && exp_row >= (4 << blk_n)) extra_ready++;
    if (busy && !in_ready && exp_row < (4 << blk_n) && in_valid) saw_drop = 1'b1;
    if (in_valid && in_ready) begin
      sb_q.push_back('{data: exp_out(in_data, blk_n), row: 5'(exp_row),
                       last: (exp_row == (4 << blk_n) - 1)});
      exp_row++;
      n_acc++;
      if (n_acc == 1) first_acc_cyc = cyc;
    end
    if (held_v) begin
      checks++;
      if (out_data !== held_data || out_row !== held_row || out_last !== held_last) begin
        errors++;
        $display("FAIL stall_hold: got row=%0d last=%0b data=%h, expected row=%0d last=%0b data=%h",
                 out_row, out_last, out_data, held_row, held_last, held_data);
      end
    end
    held_v    = out_valid && !out_ready;
    held_data = out_data;
    held_row  = out_row;
    held_last = out_last;
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (out_valid && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got row=%0d data=%h, expected no output", out_row, out_data);
      end else begin
        e = sb_q.pop_front();
        if (out_data !== e.data || out_row !== e.row || out_last !== e.last) begin
          errors++;
          $display("FAIL sb_compare: got row=%0d last=%0b data=%h, expected row=%0d last=%0b data=%h",
                   out_row, out_last, out_data, e.row, e.last, e.data);
        end
      end
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_acc = 0; n_out = 0; done_cnt = 0; done_cyc = -1; extra_ready = 0;
    first_acc_cyc = -1; first_vld_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    done_busy = 1'b0; saw_drop = 1'b0; exp_row = 0;
  endtask

  task automatic start_block(input int n);
    clear_stats();
    blk_n     = n;
    cfg_n     = 2'(n);
    cfg_start = 1'b1;
    sb_cycle();
    cfg_start = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic finish_block(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_int({name, "_sb_empty"}, sb_q.size(), 0);
    check_int({name, "_done_once"}, done_cnt, 1);
    check_int({name, "_busy_at_done"}, int'(done_busy), 0);
    check_int({name, "_done_after_last"}, done_cyc, last_out_cyc + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_n = 2'b00; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1; held_v = 1'b0; cyc = 0; blk_n = 0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, in_ready, out_valid, out_last} !== 5'b0 || out_row !== 5'd0 ||
        core_n !== 2'b00 || core_x !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b in_ready=%b out_valid=%b out_last=%b row=%0d core_n=%b, expected all zero",
               busy, done, in_ready, out_valid, out_last, out_row, core_n);
    end
    rst = 1'b0;
  endtask

  // Four rows, one non-zero lane each, with no backpressure.
  task automatic test_small_block();
    start_block(0);
    check_int("small_busy_after_start", int'(busy), 1);
    in_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_data = {16'(exp_row + 1), 496'd0};
      sb_cycle();
    end
    check_int("small_accepts", n_acc, 4);
    check_int("small_outputs", n_out, 4);
    check_int("small_ready_after_s", extra_ready, 0);
    check_int("small_latency", first_vld_cyc - first_acc_cyc, 2);
    check_int("small_no_drop", int'(saw_drop), 0);
    finish_block("small");
  endtask

  // 32 rows with continuous valid and ready.
  task automatic test_back_to_back();
    start_block(3);
    in_valid = 1'b1;
    for (int c = 0; c < 45; c++) begin
      in_data = rand_row();
      sb_cycle();
    end
    check_int("b2b_accepts", n_acc, 32);
    check_int("b2b_outputs", n_out, 32);
    check_int("b2b_consecutive", last_out_cyc - first_out_cyc, 31);
    check_int("b2b_no_33rd", extra_ready, 0);
    finish_block("b2b");
  endtask

  // Output ready toggles every cycle; the pipeline has to fill and stall.
  task automatic test_stall();
    start_block(1);
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 2 == 0);
      in_data   = rand_row();
      sb_cycle();
    end
    check_int("stall_accepts", n_acc, 8);
    check_int("stall_outputs", n_out, 8);
    check_int("stall_ready_dropped", int'(saw_drop), 1);
    finish_block("stall");
  endtask

  // A cfg_start issued mid-block must not change the block.
  task automatic test_ignore_start();
    logic pulsed;
    pulsed = 1'b0;
    start_block(1);
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_data = rand_row();
      if (n_acc == 3 && !pulsed) begin
        cfg_start = 1'b1;
        cfg_n     = 2'b11;
        pulsed    = 1'b1;
        sb_cycle();
        cfg_start = 1'b0;
        check_int("ignore_core_n_mid", int'(core_n), 1);
      end else begin
        sb_cycle();
      end
    end
    check_int("ignore_accepts", n_acc, 8);
    check_int("ignore_outputs", n_out, 8);
    check_int("ignore_core_n_end", int'(core_n), 1);
    finish_block("ignore");
  endtask

  // Reset after five of sixteen rows, then run a fresh block.
  task automatic test_rst_mid_block();
    start_block(2);
    in_valid = 1'b1;
    for (int c = 0; c < 20 && n_acc < 5; c++) begin
      in_data = rand_row() | {16'h0001, 496'd0};
      sb_cycle();
    end
    check_int("rst_pre_accepts", n_acc, 5);
    in_valid = 1'b0;
    rst      = 1'b1;
    #2;
    checks++;
    if ({busy, done, in_ready, out_valid, out_last} !== 5'b0 || out_row !== 5'd0 ||
        core_n !== 2'b00 || core_x !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_mid_values: got busy=%b done=%b in_ready=%b out_valid=%b core_n=%b core_x=%h, expected all zero",
               busy, done, in_ready, out_valid, core_n, core_x);
    end
    sb_q.delete();
    held_v = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    for (int c = 0; c < 4; c++) sb_cycle();
    check_int("rst_no_done", done_cnt, 0);
    check_int("rst_idle_busy", int'(busy), 0);
    start_block(0);
    in_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      in_data = rand_row();
      sb_cycle();
    end
    check_int("rst_new_accepts", n_acc, 4);
    check_int("rst_new_outputs", n_out, 4);
    finish_block("rst_new");
  endtask

  // All lanes 7FFF with S=4: check the lanes at or above S.
  task automatic test_lane_mask();
    logic [511:0] want_cx, want_out;
`ifdef DCT_LANE_MASK_EN
    want_cx  = {{4{16'h7FFF}}, {28{16'h0000}}};
    want_out = {{4{16'h8000}}, {28{16'h0000}}};
`else
    want_cx  = {32{16'h7FFF}};
    want_out = {32{16'h8000}};
`endif
    start_block(0);
    in_valid = 1'b1;
    in_data  = {32{16'h7FFF}};
    sb_cycle();
    checks++;
    if (core_x !== want_cx) begin
      errors++;
      $display("FAIL lane_core_x: got %h, expected %h", core_x, want_cx);
    end
    sb_cycle();
    checks++;
    if (!out_valid || out_data !== want_out) begin
      errors++;
      $display("FAIL lane_out_data: got valid=%b data=%h, expected valid=1 data=%h",
               out_valid, out_data, want_out);
    end
    for (int c = 0; c < 10; c++) sb_cycle();
    check_int("lane_outputs", n_out, 4);
    finish_block("lane");
  endtask

  initial begin
    test_reset();
    test_small_block();
    test_back_to_back();
    test_stall();
    test_ignore_start();
    test_rst_mid_block();
    test_lane_mask();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
